// File: rtl/pergate_gatefn_seq.sv
// Sequencer that walks nVals operand pairs through one shared gate-function unit,
// issuing one evaluation at a time and collecting the results into gatefn.
module pergate_gatefn_seq #(
   parameter int gate_fn     = 0,
   parameter int nVals       = 4,
   parameter int F_NBITS     = 16,
   parameter int GATEFN_BITS = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       en,
   input  logic                       mux_sel,
   input  logic [F_NBITS*nVals-1:0]   in0,
   input  logic [F_NBITS*nVals-1:0]   in1,
   output logic [GATEFN_BITS-1:0]     fn_gate_fn,
   output logic                       fn_en,
   output logic                       fn_mux_sel,
   output logic [F_NBITS-1:0]         fn_in0,
   output logic [F_NBITS-1:0]         fn_in1,
   input  logic                       fn_ready,
   input  logic [F_NBITS-1:0]         fn_out,
   output logic [F_NBITS*nVals-1:0]   gatefn,
   output logic                       ready,
   output logic                       ready_pulse,
   output logic [1:0]                 state_dbg
);

   localparam int IDX_W = (nVals > 1) ? $clog2(nVals) : 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } state_t;

   state_t                     state_q, state_d;
   logic [IDX_W-1:0]           idx_q;
   logic [F_NBITS*nVals-1:0]   in0_q, in1_q, gatefn_q;
   logic                       mux_q;
   logic                       fn_ready_q;
   logic                       ready_pulse_q;
   logic                       accept;
   logic                       done;
   logic                       last;

   // Handshake: a request is taken when en=1 while ready=1 (IDLE only); each
   // evaluation is a one-cycle fn_en, and the unit signals completion by a
   // 0->1 transition of its fn_ready level, with fn_out valid in that cycle.
   assign accept = (state_q == IDLE) && en;
   assign done   = (state_q == WAIT) && fn_ready && !fn_ready_q;
   assign last   = (idx_q == IDX_W'(nVals - 1));

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (en) state_d = ISSUE;
         ISSUE:   state_d = WAIT;
         WAIT:    if (done) state_d = last ? IDLE : ISSUE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         idx_q         <= '0;
         in0_q         <= '0;
         in1_q         <= '0;
         mux_q         <= 1'b0;
         gatefn_q      <= '0;
         fn_ready_q    <= 1'b1;
         ready_pulse_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         ready_pulse_q <= done && last;
         // Preset high on accept so a level already high is never taken as an edge.
         fn_ready_q    <= accept ? 1'b1 : fn_ready;
         if (accept) begin
            in0_q <= in0;
            in1_q <= in1;
            mux_q <= mux_sel;
            idx_q <= '0;
         end
         if (done) begin
            gatefn_q[idx_q*F_NBITS +: F_NBITS] <= fn_out;
            if (!last) idx_q <= idx_q + IDX_W'(1);
         end
      end
   end

   assign fn_gate_fn  = GATEFN_BITS'(gate_fn);
   assign fn_en       = (state_q == ISSUE);
   assign fn_mux_sel  = mux_q;
   assign fn_in0      = in0_q[idx_q*F_NBITS +: F_NBITS];
   assign fn_in1      = in1_q[idx_q*F_NBITS +: F_NBITS];
   assign gatefn      = gatefn_q;
   assign ready       = (state_q == IDLE);
   assign ready_pulse = ready_pulse_q;
   assign state_dbg   = state_q;

endmodule

// File: tb/tb_pergate_gatefn_seq.sv
// Directed bench for pergate_gatefn_seq: a 4-value add sequencer and a 1-value
// mul sequencer, each served by a behavioural gate-function unit of latency 3.
module tb_pergate_gatefn_seq;

   localparam int FW = 16;
   localparam int NV = 4;
   localparam int L  = 3;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst;

   // 4-value add instance
   logic                 en, mux_sel;
   logic [NV*FW-1:0]     in0, in1, gatefn;
   logic [1:0]           fn_gate_fn, state_dbg;
   logic                 fn_en, fn_mux_sel, ready, ready_pulse;
   logic [FW-1:0]        fn_in0, fn_in1;
   logic                 fn_ready = 1'b1;
   logic [FW-1:0]        fn_out = '0;

   // 1-value mul instance
   logic                 en_b, mux_sel_b;
   logic [FW-1:0]        in0_b, in1_b, gatefn_b;
   logic [1:0]           fn_gate_fn_b, state_dbg_b;
   logic                 fn_en_b, fn_mux_sel_b, ready_b, ready_pulse_b;
   logic [FW-1:0]        fn_in0_b, fn_in1_b;
   logic                 fn_ready_b = 1'b1;
   logic [FW-1:0]        fn_out_b = '0;

   pergate_gatefn_seq #(.gate_fn(0), .nVals(NV), .F_NBITS(FW), .GATEFN_BITS(2)) dut (
      .clk(clk), .rst(rst), .en(en), .mux_sel(mux_sel), .in0(in0), .in1(in1),
      .fn_gate_fn(fn_gate_fn), .fn_en(fn_en), .fn_mux_sel(fn_mux_sel),
      .fn_in0(fn_in0), .fn_in1(fn_in1), .fn_ready(fn_ready), .fn_out(fn_out),
      .gatefn(gatefn), .ready(ready), .ready_pulse(ready_pulse), .state_dbg(state_dbg)
   );

   pergate_gatefn_seq #(.gate_fn(1), .nVals(1), .F_NBITS(FW), .GATEFN_BITS(2)) dut_b (
      .clk(clk), .rst(rst), .en(en_b), .mux_sel(mux_sel_b), .in0(in0_b), .in1(in1_b),
      .fn_gate_fn(fn_gate_fn_b), .fn_en(fn_en_b), .fn_mux_sel(fn_mux_sel_b),
      .fn_in0(fn_in0_b), .fn_in1(fn_in1_b), .fn_ready(fn_ready_b), .fn_out(fn_out_b),
      .gatefn(gatefn_b), .ready(ready_b), .ready_pulse(ready_pulse_b), .state_dbg(state_dbg_b)
   );

   // ---------------- behavioural units ----------------
   // fn_ready drops in the fn_en cycle and is high again L cycles later.
   // stuck_first keeps it high through the first WAIT cycle of the next issue,
   // then low for 5 cycles before rising.
   int            rise_a = 0, drop_a = 0, rise_b = 0;
   logic [FW-1:0] res_a, res_b;
   bit            stuck_first = 1'b0;

   always @(negedge clk) begin
      if (fn_en) begin
         res_a = fn_in0 + fn_in1;
         if (stuck_first) begin
            stuck_first = 1'b0;
            drop_a = 1;
            rise_a = 6;
         end else begin
            fn_ready = 1'b0;
            drop_a = 0;
            rise_a = L;
         end
      end else begin
         if (drop_a > 0) begin
            drop_a--;
            if (drop_a == 0) fn_ready = 1'b0;
         end
         if (rise_a > 0) begin
            rise_a--;
            if (rise_a == 0) begin
               fn_ready = 1'b1;
               fn_out   = res_a;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (fn_en_b) begin
         res_b = FW'(fn_in0_b * fn_in1_b);
         fn_ready_b = 1'b0;
         rise_b = L;
      end else if (rise_b > 0) begin
         rise_b--;
         if (rise_b == 0) begin
            fn_ready_b = 1'b1;
            fn_out_b   = res_b;
         end
      end
   end

   // ---------------- event monitors ----------------
   int cyc = 0;
   int en_cnt = 0, rp_cnt = 0, en_cnt_b = 0, rp_cnt_b = 0;
   int en_cyc[$];

   always @(posedge clk) begin
      cyc++;
      if (fn_en) begin
         en_cnt++;
         en_cyc.push_back(cyc);
      end
      if (ready_pulse)   rp_cnt++;
      if (fn_en_b)       en_cnt_b++;
      if (ready_pulse_b) rp_cnt_b++;
   end

   // ---------------- scoreboard ----------------
   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   // Latency counts the accept cycle as 0; returns the cycle number in which ready is seen high.
   task automatic run_req(input logic [NV*FW-1:0] a0, input logic [NV*FW-1:0] a1,
                          input logic ms, input bit zero_after, output int lat);
      @(negedge clk);
      in0 = a0; in1 = a1; mux_sel = ms; en = 1'b1;
      lat = 0;
      @(negedge clk);
      en = 1'b0;
      lat = 1;
      if (zero_after) begin
         in0 = '0; in1 = '0; mux_sel = 1'b0;
      end
      while (!ready && lat < 200) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic clear_counts();
      en_cnt = 0; rp_cnt = 0;
      en_cyc.delete();
   endtask

   localparam logic [NV*FW-1:0] A0   = {16'd4, 16'd3, 16'd2, 16'd1};
   localparam logic [NV*FW-1:0] A1   = {16'd40, 16'd30, 16'd20, 16'd10};
   localparam logic [NV*FW-1:0] SUM  = {16'd44, 16'd33, 16'd22, 16'd11};
   localparam logic [NV*FW-1:0] B0   = {16'd400, 16'd300, 16'd200, 16'd100};
   localparam logic [NV*FW-1:0] B1   = {16'd5, 16'd6, 16'd7, 16'd8};
   localparam logic [NV*FW-1:0] BSUM = {16'd405, 16'd306, 16'd207, 16'd108};

   initial begin
      int lat;
      int rp_q[$];
      logic rdy18, rdy35;

      rst = 1'b1; en = 1'b0; mux_sel = 1'b0; in0 = '0; in1 = '0;
      en_b = 1'b0; mux_sel_b = 1'b0; in0_b = '0; in1_b = '0;
      repeat (2) @(negedge clk);
      // reset wins over a simultaneous start request
      en = 1'b1; en_b = 1'b1; in0 = A0; in1 = A1; mux_sel = 1'b1;
      @(negedge clk);
      rst = 1'b0; en = 1'b0; en_b = 1'b0;
      check("rst_ready", ready, 1);
      check("rst_ready_pulse", ready_pulse, 0);
      check("rst_fn_en", fn_en, 0);
      check("rst_gatefn", gatefn, 0);
      check("rst_fn_in0", fn_in0, 0);
      check("rst_fn_in1", fn_in1, 0);
      check("rst_fn_mux_sel", fn_mux_sel, 0);
      check("rst_state", state_dbg, 0);
      check("fn_gate_fn_add", fn_gate_fn, 0);
      check("rst_b_ready", ready_b, 1);
      check("rst_b_gatefn", gatefn_b, 0);
      @(negedge clk);
      check("rst_pri_no_issue", fn_en, 0);
      check("rst_pri_ready", ready, 1);

      // basic add request: 4 issues 4 cycles apart, ready in cycle 17
      clear_counts();
      run_req(A0, A1, 1'b1, 1'b0, lat);
      check("basic_latency", lat, 17);
      check("basic_ready_pulse_hi", ready_pulse, 1);
      check("basic_gatefn", gatefn, SUM);
      check("basic_mux_sel", fn_mux_sel, 1);
      @(negedge clk);
      check("basic_ready_pulse_lo", ready_pulse, 0);
      check("basic_fn_en_count", en_cnt, 4);
      check("basic_rp_count", rp_cnt, 1);
      for (int i = 1; i < en_cyc.size(); i++)
         check($sformatf("basic_issue_gap%0d", i), en_cyc[i] - en_cyc[i-1], 4);

      // second pattern overwrites every entry
      clear_counts();
      run_req(B0, B1, 1'b0, 1'b0, lat);
      check("pat2_latency", lat, 17);
      check("pat2_gatefn", gatefn, BSUM);
      check("pat2_mux_sel", fn_mux_sel, 0);

      // operands zeroed right after accept must not disturb the request
      clear_counts();
      run_req(A0, A1, 1'b1, 1'b1, lat);
      check("latch_latency", lat, 17);
      check("latch_gatefn", gatefn, SUM);
      check("latch_mux_sel", fn_mux_sel, 1);
      repeat (5) @(negedge clk);
      check("idle_hold_gatefn", gatefn, SUM);
      check("idle_hold_fn_en", en_cnt, 4);

      // en held high for 40 cycles: new request taken in each ready_pulse cycle
      clear_counts();
      in0 = B0; in1 = B1; mux_sel = 1'b0;
      rdy18 = 1'b1; rdy35 = 1'b1;
      for (int c = 0; c < 70; c++) begin
         @(negedge clk);
         en = (c < 40);
         if (ready_pulse) rp_q.push_back(c);
         if (c == 18) rdy18 = ready;
         if (c == 35) rdy35 = ready;
      end
      en = 1'b0;
      check("b2b_rp_count", rp_cnt, 3);
      check("b2b_fn_en_count", en_cnt, 12);
      check("b2b_rp_q_size", rp_q.size(), 3);
      for (int k = 0; k < rp_q.size(); k++)
         check($sformatf("b2b_rp_cycle%0d", k), rp_q[k], 17 * (k + 1));
      check("b2b_busy_after_pulse1", rdy18, 0);
      check("b2b_busy_after_pulse2", rdy35, 0);
      check("b2b_gatefn", gatefn, BSUM);

      // reset during the WAIT of idx=2 abandons the request
      clear_counts();
      @(negedge clk);
      in0 = A0; in1 = A1; mux_sel = 1'b1; en = 1'b1;
      @(negedge clk);
      en = 1'b0;
      for (int t = 0; t < 100 && en_cnt < 3; t++) @(negedge clk);
      check("rstw_reached_idx2", en_cnt, 3);
      check("rstw_in_wait", state_dbg, 2);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("rstw_ready", ready, 1);
      check("rstw_ready_pulse", ready_pulse, 0);
      check("rstw_gatefn", gatefn, 0);
      check("rstw_fn_en", fn_en, 0);
      repeat (8) @(negedge clk);
      check("rstw_late_edge_gatefn", gatefn, 0);
      check("rstw_late_edge_ready", ready, 1);
      check("rstw_late_edge_fn_en", en_cnt, 3);
      check("rstw_late_edge_rp", rp_cnt, 0);

      // fn_ready high at WAIT entry of idx=0: only its later rise completes
      clear_counts();
      stuck_first = 1'b1;
      run_req(A0, A1, 1'b0, 1'b0, lat);
      check("stuck_latency", lat, 20);
      check("stuck_gatefn", gatefn, SUM);
      check("stuck_fn_en_count", en_cnt, 4);
      if (en_cyc.size() >= 2) check("stuck_first_gap", en_cyc[1] - en_cyc[0], 7);
      else check("stuck_issue_count", en_cyc.size(), 4);

      // nVals=1 multiply instance
      en_cnt_b = 0; rp_cnt_b = 0;
      @(negedge clk);
      in0_b = 16'd7; in1_b = 16'd6; mux_sel_b = 1'b1; en_b = 1'b1;
      @(negedge clk);
      en_b = 1'b0;
      lat = 1;
      while (!ready_b && lat < 200) begin
         @(negedge clk);
         lat++;
      end
      check("mul_latency", lat, 5);
      check("mul_gatefn", gatefn_b, 42);
      check("mul_ready_pulse", ready_pulse_b, 1);
      check("mul_fn_gate_fn", fn_gate_fn_b, 1);
      check("mul_mux_sel", fn_mux_sel_b, 1);
      @(negedge clk);
      check("mul_fn_en_count", en_cnt_b, 1);
      check("mul_rp_count", rp_cnt_b, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
